// File: rtl/debug_string_uart_tx.sv
// Debug-string consumer: latches a right-aligned packed string, skips NUL bytes
// and serialises the remaining characters as 8N1 UART frames, LSB first.
module debug_string_uart_tx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned STR_BYTES = 80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [STR_BYTES*8-1:0] debug_string,
    input  logic                   debug_send,
    output logic                   debug_ready,
    output logic                   uart_tx,
    output logic                   busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = (STR_BYTES > 1) ? $clog2(STR_BYTES) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_TOP   = IW'(STR_BYTES - 1);

    typedef enum logic [2:0] {IDLE, SCAN, START, DATA, STOP} state_t;

    state_t                      state, state_next;
    logic [STR_BYTES-1:0][7:0]   shreg, shreg_next;
    logic [IW-1:0]               idx, idx_next;
    logic [CW-1:0]               cnt, cnt_next;
    logic [2:0]                  bit_idx, bit_next;
    logic [7:0]                  tx_data, data_next;
    logic                        tx_next;
    logic                        baud_done;

    assign debug_ready = (state == IDLE);
    assign busy        = ~debug_ready;
    assign baud_done   = (cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            idx     <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            tx_data <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            idx     <= idx_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            tx_data <= data_next;
            uart_tx <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        idx_next   = idx;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        data_next  = tx_data;
        tx_next    = uart_tx;
        case (state)
            IDLE: begin
                if (debug_send) begin
                    shreg_next = debug_string;
                    idx_next   = IDX_TOP;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (shreg[idx] == 8'h00) begin
                    if (idx == '0) state_next = IDLE;
                    else           idx_next   = idx - IW'(1);
                end else begin
                    // start bit is driven on the same edge the character is found
                    data_next  = shreg[idx];
                    cnt_next   = '0;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    tx_next    = tx_data[0];
                    state_next = DATA;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        tx_next  = tx_data[bit_idx + 3'd1];
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    cnt_next = '0;
                    tx_next  = 1'b1;
                    if (idx == '0) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx - IW'(1);
                        state_next = SCAN;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
